// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings and default bit timing.
// Used by both the receive and transmit sides.
package uart_pkg;

    localparam int UART_CLKS_PER_BIT = 868;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_IDLE = 3'd4
    } uart_state_t;

endpackage

// File: rtl/uart_sync.sv
// Multi-flop synchronizer for a single asynchronous input bit.
// Latency: SYNC_STAGES cycles; no backpressure (free-running).
// All stages reset to RST_VAL so the output is defined during reset.
module uart_sync #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b1
) (
    input  logic clk,
    input  logic reset_b,
    input  logic d_in,
    output logic d_out
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], d_in};
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            sync_q <= {SYNC_STAGES{RST_VAL}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign d_out = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: oversampled start/data/stop decode into a one-entry output register.
// Latency: byte visible the cycle after the mid-stop-bit sample (plus SYNC_STAGES on the line).
// Backpressure: none; an unacknowledged byte is overwritten and RX_Overrun pulses.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       reset_b,
    input  logic       RX_Data_in,
    input  logic       RX_Ack,
    output logic [7:0] RX_Data_out,
    output logic       RX_Valid,
    output logic       RX_Frame_Err,
    output logic       RX_Overrun,
    output logic       RX_Busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(CLKS_PER_BIT - 1);

    logic rx_s;

    uart_state_t   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          ferr_q, ferr_d;
    logic          ovr_q, ovr_d;

    uart_sync #(
        .SYNC_STAGES (SYNC_STAGES),
        .RST_VAL     (1'b1)
    ) u_sync (
        .clk     (clk),
        .reset_b (reset_b),
        .d_in    (RX_Data_in),
        .d_out   (rx_s)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = valid_q;
        ferr_d  = 1'b0;
        ovr_d   = 1'b0;

        if (RX_Ack) begin
            valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                bit_d = '0;
                if (!rx_s) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (cnt_q == HALF_CNT) begin
                    cnt_d   = '0;
                    // A start bit that is high again at mid-bit was a glitch.
                    state_d = rx_s ? ST_IDLE : ST_DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_DATA: begin
                if (cnt_q == FULL_CNT) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = ST_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_STOP: begin
                if (cnt_q == FULL_CNT) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        // Ack in the accept cycle frees the slot, so no overrun.
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        ovr_d   = valid_q && !RX_Ack;
                        state_d = ST_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = ST_WAIT_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_WAIT_IDLE: begin
                if (rx_s) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign RX_Data_out  = data_q;
    assign RX_Valid     = valid_q;
    assign RX_Frame_Err = ferr_q;
    assign RX_Overrun   = ovr_q;
    assign RX_Busy      = (state_q != ST_IDLE);

endmodule
